uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command-frame controller that sits behind uart_rx. It consumes received bytes and
//  frames them as 4-byte register-write commands: SYNC, ADDR, DATA, CHK. It validates
//  the checksum and enforces an inter-byte timeout. Each good frame is issued as one
//  valid/ready write on the register bus. Status counters are kept for debug LEDs.
// PARAMETERS
//  SYS_CLK_FREQ   48_000_000  system clock, Hz
//  BAUD_RATE      9_600       UART baud; BIT_PERIOD = SYS_CLK_FREQ/BAUD_RATE
//  SYNC_BYTE      8'hA5       frame start marker
//  TIMEOUT_BYTES  4           inter-byte timeout, in byte-times (10*BIT_PERIOD each)
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  reset_n      in   1  synchronous, active-low reset
//  rx_data      in   8  byte from uart_rx; sampled only when rx_ready=1
//  rx_ready     in   1  1-cycle strobe from uart_rx: rx_data is valid
//  cmd_addr     out  8  register address; stable while cmd_valid=1
//  cmd_wdata    out  8  register write data; stable while cmd_valid=1
//  cmd_valid    out  1  write request; held until accepted
//  cmd_ready    in   1  register bus accepts when cmd_valid & cmd_ready
//  busy         out  1  high in every state except WAIT_SYNC
//  chk_err      out  1  1-cycle pulse: checksum mismatch
//  timeout_err  out  1  1-cycle pulse: inter-byte timeout fired
//  overrun_err  out  1  1-cycle pulse: byte arrived during ISSUE and was dropped
//  frame_cnt    out  8  count of accepted commands; wraps 255->0
//  err_cnt      out  8  sum of chk/timeout/overrun events; saturates at 255
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - state=WAIT_SYNC; all outputs 0; timeout counter cleared.
//   - Reset overrides everything, including a mid-frame state or a pending cmd_valid.
//  States and transitions (each transition happens on an rx_ready cycle unless noted):
//   - WAIT_SYNC: a byte == SYNC_BYTE -> GET_ADDR. Any other byte is silently ignored.
//   - GET_ADDR: latch the byte as addr -> GET_DATA. A SYNC_BYTE value is taken as addr
//     data; there is no resync.
//   - GET_DATA: latch the byte as data -> GET_CHK.
//   - GET_CHK: compare the byte with (addr + data) mod 256 (8-bit wrap).
//     - Match: drive cmd_addr/cmd_wdata, set cmd_valid=1 on the next cycle -> ISSUE.
//     - Mismatch: chk_err pulse -> WAIT_SYNC.
//   - ISSUE: hold cmd_valid, cmd_addr and cmd_wdata until cmd_valid & cmd_ready at a
//     posedge. On that edge: cmd_valid<=0, frame_cnt+1 -> WAIT_SYNC.
//     - No timeout applies in ISSUE; it waits indefinitely.
//     - An rx_ready in ISSUE: byte dropped, overrun_err pulse. Acceptance still proceeds
//       in the same cycle if cmd_ready=1.
//  Timeout (GET_ADDR, GET_DATA, GET_CHK only):
//   - TIMEOUT_CYCLES = TIMEOUT_BYTES*10*BIT_PERIOD.
//   - The counter clears on entry to GET_ADDR and on every rx_ready, and increments
//     otherwise.
//   - When it reaches TIMEOUT_CYCLES-1 with no rx_ready: timeout_err pulse -> WAIT_SYNC.
//   - If rx_ready and expiry coincide, the byte wins: it is processed normally and the
//     counter clears.
//   - Counter width is $clog2(TIMEOUT_CYCLES).
//  Latency: the CHK byte strobe is at cycle N; cmd_valid=1 at cycle N+1. The earliest
//   acceptance is cycle N+1; back in WAIT_SYNC at N+2.
//  err_cnt: increments by 1 per cycle in which any error pulse fires. It stops at 255.
//   Only one error can fire per cycle by construction.
//  Error pulses are exactly one cycle wide. No pulse fires during or on exit from reset.
//  At most one byte is processed per cycle. rx_data is ignored when rx_ready=0.
// TESTING
//  1. Bytes A5,10,22,32 with cmd_ready=1 -> cmd_valid 1 cycle after the CHK strobe with
//     addr=10 and wdata=22; frame_cnt=1; no error pulses.
//  2. Bytes A5,F0,20,10 ((F0+20) wraps to 10) with cmd_ready held 0 for 50 cycles, then
//     1 -> cmd_valid and payload stable for all 50 cycles; accepted once; frame_cnt+1.
//  3. Bytes A5,01,02,04 -> chk_err pulses once; err_cnt=1; no cmd_valid; next good
//     frame is accepted.
//  4. Bytes A5,01, then idle for 4 byte-times -> timeout_err on cycle TIMEOUT_CYCLES
//     after the last strobe. A strobe on that exact cycle suppresses the timeout.
//  5. Bytes 00,FF,A5,33,44,77 -> leading garbage ignored; cmd addr=33, wdata=44.
//     A byte sent during ISSUE -> overrun_err pulse.
//  6. reset_n=0 in GET_DATA and again while cmd_valid=1 -> all outputs 0 next cycle;
//     state WAIT_SYNC. After 256 errors, err_cnt stays at 255.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if
//   Bundles the two handshakes around the command controller: the byte stream
//   from uart_rx and the valid/ready register-write bus.
//   master : the controller (consumes rx bytes, drives the write request)
//   slave  : the surroundings (uart_rx byte source and register bus sink)
//   Signals:
//     rx_data   [7:0]  received byte, meaningful only while rx_ready=1
//     rx_ready         1-cycle strobe marking rx_data valid
//     cmd_addr  [7:0]  register address of the pending write
//     cmd_wdata [7:0]  register data of the pending write
//     cmd_valid        write request, held until accepted
//     cmd_ready        register bus accepts when cmd_valid & cmd_ready
interface uart_cmd_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       cmd_valid;
   logic       cmd_ready;

   modport master (
      input  rx_data, rx_ready, cmd_ready,
      output cmd_addr, cmd_wdata, cmd_valid
   );

   modport slave (
      output rx_data, rx_ready, cmd_ready,
      input  cmd_addr, cmd_wdata, cmd_valid
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Frames bytes from uart_rx into 4-byte register-write commands
//   (SYNC, ADDR, DATA, CHK), validates the 8-bit additive checksum, enforces an
//   inter-byte timeout and issues each good frame as one valid/ready write.
//   Ports:
//     clk          system clock, all logic on posedge
//     reset_n      synchronous active-low reset
//     bus          uart_cmd_ctrl_if.master (rx byte stream + register bus)
//     busy         high in every state except WAIT_SYNC
//     chk_err      1-cycle pulse on checksum mismatch
//     timeout_err  1-cycle pulse when the inter-byte timeout expires
//     overrun_err  1-cycle pulse when a byte is dropped during ISSUE
//     frame_cnt    accepted-command count, wraps
//     err_cnt      error-event count, saturates at 255
module uart_cmd_ctrl #(
   parameter int         SYS_CLK_FREQ  = 48_000_000,
   parameter int         BAUD_RATE     = 9_600,
   parameter logic [7:0] SYNC_BYTE     = 8'hA5,
   parameter int         TIMEOUT_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   uart_cmd_ctrl_if.master        bus,
   output logic                   busy,
   output logic                   chk_err,
   output logic                   timeout_err,
   output logic                   overrun_err,
   output logic [7:0]             frame_cnt,
   output logic [7:0]             err_cnt
);

   localparam int BIT_PERIOD     = SYS_CLK_FREQ / BAUD_RATE;
   localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * BIT_PERIOD;
   localparam int TMO_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_SYNC,
      GET_ADDR,
      GET_DATA,
      GET_CHK,
      ISSUE
   } state_t;

   state_t           state_reg, state_next;
   logic [7:0]       addr_reg, addr_next;
   logic [7:0]       data_reg, data_next;
   logic [TMO_W-1:0] tmo_reg, tmo_next;
   logic             cmd_valid_reg, cmd_valid_next;
   logic [7:0]       frame_reg, frame_next;
   logic [7:0]       err_reg, err_next;
   logic             chk_err_reg, chk_err_next;
   logic             timeout_reg, timeout_next;
   logic             overrun_reg, overrun_next;
   logic [7:0]       chk_sum;
   logic             in_frame;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= WAIT_SYNC;
         addr_reg      <= '0;
         data_reg      <= '0;
         tmo_reg       <= '0;
         cmd_valid_reg <= 1'b0;
         frame_reg     <= '0;
         err_reg       <= '0;
         chk_err_reg   <= 1'b0;
         timeout_reg   <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         data_reg      <= data_next;
         tmo_reg       <= tmo_next;
         cmd_valid_reg <= cmd_valid_next;
         frame_reg     <= frame_next;
         err_reg       <= err_next;
         chk_err_reg   <= chk_err_next;
         timeout_reg   <= timeout_next;
         overrun_reg   <= overrun_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      data_next      = data_reg;
      tmo_next       = tmo_reg;
      cmd_valid_next = cmd_valid_reg;
      frame_next     = frame_reg;
      err_next       = err_reg;
      chk_err_next   = 1'b0;
      timeout_next   = 1'b0;
      overrun_next   = 1'b0;
      chk_sum        = addr_reg + data_reg;
      in_frame       = (state_reg == GET_ADDR) || (state_reg == GET_DATA) ||
                       (state_reg == GET_CHK);

      // Timeout only fires on cycles without a byte, so a byte arriving on the
      // expiry cycle always wins and the per-state byte handling below never
      // conflicts with it.
      if (in_frame) begin
         if (bus.rx_ready) begin
            tmo_next = '0;
         end else if (tmo_reg == TMO_LAST) begin
            tmo_next     = '0;
            timeout_next = 1'b1;
            state_next   = WAIT_SYNC;
         end else begin
            tmo_next = tmo_reg + TMO_W'(1);
         end
      end

      case (state_reg)
         WAIT_SYNC: begin
            if (bus.rx_ready && (bus.rx_data == SYNC_BYTE)) begin
               tmo_next   = '0;
               state_next = GET_ADDR;
            end
         end
         GET_ADDR: begin
            // A second SYNC value here is ordinary address data.
            if (bus.rx_ready) begin
               addr_next  = bus.rx_data;
               state_next = GET_DATA;
            end
         end
         GET_DATA: begin
            if (bus.rx_ready) begin
               data_next  = bus.rx_data;
               state_next = GET_CHK;
            end
         end
         GET_CHK: begin
            if (bus.rx_ready) begin
               if (bus.rx_data == chk_sum) begin
                  cmd_valid_next = 1'b1;
                  state_next     = ISSUE;
               end else begin
                  chk_err_next = 1'b1;
                  state_next   = WAIT_SYNC;
               end
            end
         end
         ISSUE: begin
            // Bytes cannot be buffered while a write is pending; drop and flag,
            // but let the handshake complete in the same cycle.
            if (bus.rx_ready) begin
               overrun_next = 1'b1;
            end
            if (cmd_valid_reg && bus.cmd_ready) begin
               cmd_valid_next = 1'b0;
               frame_next     = frame_reg + 8'd1;
               state_next     = WAIT_SYNC;
            end
         end
         default: begin
            state_next = WAIT_SYNC;
         end
      endcase

      if ((chk_err_next || timeout_next || overrun_next) && (err_reg != 8'hFF)) begin
         err_next = err_reg + 8'd1;
      end
   end

   // Address/data registers double as the command payload: they cannot change
   // while in ISSUE, so the payload is stable for as long as cmd_valid is held.
   assign bus.cmd_addr  = addr_reg;
   assign bus.cmd_wdata = data_reg;
   assign bus.cmd_valid = cmd_valid_reg;
   assign busy          = (state_reg != WAIT_SYNC);
   assign chk_err       = chk_err_reg;
   assign timeout_err   = timeout_reg;
   assign overrun_err   = overrun_reg;
   assign frame_cnt     = frame_reg;
   assign err_cnt       = err_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

   localparam int SYS_CLK  = 1000;
   localparam int BAUD     = 100;
   localparam int T_CYC    = 4 * 10 * (SYS_CLK / BAUD);   // 400 cycles

   logic       clk = 1'b0;
   logic       reset_n;
   logic       busy, chk_err, timeout_err, overrun_err;
   logic [7:0] frame_cnt, err_cnt;

   uart_cmd_ctrl_if bus ();

   uart_cmd_ctrl #(
      .SYS_CLK_FREQ (SYS_CLK),
      .BAUD_RATE    (BAUD),
      .SYNC_BYTE    (8'hA5),
      .TIMEOUT_BYTES(4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus.master),
      .busy       (busy),
      .chk_err    (chk_err),
      .timeout_err(timeout_err),
      .overrun_err(overrun_err),
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;
   logic [15:0] sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Strobe one byte for one cycle; returns at the negedge just after the
   // posedge that sampled it.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   function automatic logic [63:0] all_outs();
      return {26'd0, bus.cmd_valid, bus.cmd_addr, bus.cmd_wdata, busy, chk_err,
              timeout_err, overrun_err, frame_cnt, err_cnt};
   endfunction

   // Scoreboard: every accepted write is popped and compared against the
   // expectation pushed when its frame was sent.
   always @(posedge clk) begin
      if (reset_n && bus.cmd_valid && bus.cmd_ready) begin
         acc_cnt++;
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL accept_unexpected observed=%0h expected=none",
                   {bus.cmd_addr, bus.cmd_wdata});
         end
         if (sb.size() != 0) begin
            logic [15:0] exp;
            exp = sb.pop_front();
            total++;
            assert ({bus.cmd_addr, bus.cmd_wdata} === exp) else begin
               bad++;
               $error("FAIL accept_payload observed=%0h expected=%0h",
                      {bus.cmd_addr, bus.cmd_wdata}, exp);
            end
            $display("accept addr=%0h wdata=%0h expected=%0h",
                     bus.cmd_addr, bus.cmd_wdata, exp);
         end
      end
   end

   initial begin
      logic stable_ok;
      logic quiet_ok;

      reset_n       = 1'b0;
      bus.rx_data   = 8'h00;
      bus.rx_ready  = 1'b0;
      bus.cmd_ready = 1'b0;
      tick(3);
      chk("reset_outputs", all_outs(), 64'd0);
      reset_n = 1'b1;
      tick(1);
      chk("post_reset_quiet", all_outs(), 64'd0);

      // 1: basic frame, immediate acceptance
      bus.cmd_ready = 1'b1;
      send_byte(8'hA5); send_byte(8'h10); send_byte(8'h22);
      sb.push_back({8'h10, 8'h22});
      send_byte(8'h32);
      chk("t1_valid_addr_data", {bus.cmd_valid, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 8'h10, 8'h22});
      chk("t1_no_err", {chk_err, timeout_err, overrun_err}, 3'b000);
      tick(1);
      chk("t1_done", {bus.cmd_valid, busy, frame_cnt}, {1'b0, 1'b0, 8'd1});

      // 2: wrapped checksum, back-pressure for 50 cycles
      bus.cmd_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'hF0); send_byte(8'h20);
      sb.push_back({8'hF0, 8'h20});
      send_byte(8'h10);
      stable_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!(bus.cmd_valid === 1'b1 && bus.cmd_addr === 8'hF0 && bus.cmd_wdata === 8'h20))
            stable_ok = 1'b0;
         tick(1);
      end
      chk("t2_hold_stable", stable_ok, 1'b1);
      chk("t2_not_accepted", {frame_cnt, acc_cnt[7:0]}, {8'd1, 8'd1});
      bus.cmd_ready = 1'b1;
      tick(1);
      chk("t2_accepted_once", {bus.cmd_valid, frame_cnt, acc_cnt[7:0]}, {1'b0, 8'd2, 8'd2});

      // 3: checksum error then recovery
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h04);
      chk("t3_chk_err", {chk_err, err_cnt, bus.cmd_valid, busy}, {1'b1, 8'd1, 1'b0, 1'b0});
      tick(1);
      chk("t3_pulse_width", chk_err, 1'b0);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
      sb.push_back({8'h01, 8'h02});
      send_byte(8'h03);
      chk("t3_recover_valid", bus.cmd_valid, 1'b1);
      tick(1);
      chk("t3_frame_cnt", frame_cnt, 8'd3);

      // 4: timeout, and strobe on the expiry cycle suppressing it
      send_byte(8'hA5); send_byte(8'h01);
      quiet_ok = 1'b1;
      for (int i = 0; i < T_CYC - 1; i++) begin
         tick(1);
         if (timeout_err !== 1'b0 || busy !== 1'b1) quiet_ok = 1'b0;
      end
      chk("t4_no_early_timeout", quiet_ok, 1'b1);
      tick(1);
      chk("t4_timeout", {timeout_err, err_cnt, busy}, {1'b1, 8'd2, 1'b0});
      tick(1);
      chk("t4_pulse_width", timeout_err, 1'b0);
      send_byte(8'hA5); send_byte(8'h01);
      tick(T_CYC - 1);
      send_byte(8'h02);
      chk("t4_suppressed", {timeout_err, busy, err_cnt}, {1'b0, 1'b1, 8'd2});
      sb.push_back({8'h01, 8'h02});
      send_byte(8'h03);
      chk("t4_frame_after_edge", bus.cmd_valid, 1'b1);
      tick(1);
      chk("t4_frame_cnt", frame_cnt, 8'd4);

      // 5: leading garbage, then overruns during ISSUE
      send_byte(8'h00); send_byte(8'hFF);
      chk("t5_garbage_ignored", {busy, err_cnt}, {1'b0, 8'd2});
      send_byte(8'hA5); send_byte(8'h33); send_byte(8'h44);
      sb.push_back({8'h33, 8'h44});
      bus.cmd_ready = 1'b0;
      send_byte(8'h77);
      chk("t5_valid", {bus.cmd_valid, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 8'h33, 8'h44});
      send_byte(8'h55);
      chk("t5_overrun", {overrun_err, err_cnt, bus.cmd_valid}, {1'b1, 8'd3, 1'b1});
      tick(1);
      chk("t5_overrun_width", overrun_err, 1'b0);
      bus.cmd_ready = 1'b1;
      send_byte(8'h66);
      chk("t5_overrun_and_accept", {overrun_err, bus.cmd_valid, frame_cnt, err_cnt},
          {1'b1, 1'b0, 8'd5, 8'd4});

      // 6: reset mid-frame and while a write is pending
      send_byte(8'hA5); send_byte(8'h12);
      reset_n = 1'b0;
      tick(1);
      chk("t6_reset_in_data", all_outs(), 64'd0);
      reset_n = 1'b1;
      bus.cmd_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'h46);
      chk("t6_pending", bus.cmd_valid, 1'b1);
      reset_n = 1'b0;
      tick(1);
      chk("t6_reset_in_issue", all_outs(), 64'd0);
      reset_n = 1'b1;
      tick(1);
      chk("t6_no_pulse_on_exit", all_outs(), 64'd0);

      for (int i = 0; i < 255; i++) begin
         send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      end
      chk("t6_err_cnt_255", err_cnt, 8'd255);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      chk("t6_err_cnt_saturated", {chk_err, err_cnt}, {1'b1, 8'd255});

      tick(2);
      chk("scoreboard_empty", sb.size(), 0);
      chk("accept_count", acc_cnt, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
